wb_arbiter_rr2: RTL and testbench

- Two-master, one-slave Wishbone classic arbiter with round-robin fairness and a bus-timeout watchdog.
- Shares the single system Wishbone port between the rv32im core (M0) and a second master such as DMA or debug (M1).
- Every downstream memory or peripheral sees one master at a time.
- A timeout returns ERR to the master if a slave never acknowledges, so a hung slave cannot deadlock the core.

---
 rtl/wb_arbiter_rr2.sv | 177 +++++++++++++++++
 tb/tb_wb_arbiter_rr2.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_rr2.sv
// Purpose : two-master / one-slave Wishbone classic arbiter, round-robin on contention, with a slave timeout watchdog.
// Latency : grant registered one cycle after CYC request; data/ACK paths are combinational (zero added latency).
// Backpres: the losing master simply sees no ACK until granted; a slave stalling TIMEOUT_CYCLES cycles gets the cycle aborted with ERR.
//
// Ports:
//   CLK_I, RST_I (async, active-low)       clock / reset
//   m0_* / m1_*                            Wishbone master-side ports (CYC/STB/WE/ADR/DAT/SEL in, ACK/ERR/DAT out)
//   CYC_O..SEL_O, ACK_I, DAT_I             Wishbone slave-side port
//   gnt_o                                  one-hot current grant (00 = idle / error cycle)
module wb_arbiter_rr2 #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    // master 0
    input  logic        m0_CYC_I,
    input  logic        m0_STB_I,
    input  logic        m0_WE_I,
    input  logic [31:0] m0_ADR_I,
    input  logic [31:0] m0_DAT_I,
    input  logic [3:0]  m0_SEL_I,
    output logic        m0_ACK_O,
    output logic        m0_ERR_O,
    output logic [31:0] m0_DAT_O,
    // master 1
    input  logic        m1_CYC_I,
    input  logic        m1_STB_I,
    input  logic        m1_WE_I,
    input  logic [31:0] m1_ADR_I,
    input  logic [31:0] m1_DAT_I,
    input  logic [3:0]  m1_SEL_I,
    output logic        m1_ACK_O,
    output logic        m1_ERR_O,
    output logic [31:0] m1_DAT_O,
    // slave side
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    output logic [31:0] ADR_O,
    output logic [31:0] DAT_O,
    output logic [3:0]  SEL_O,
    input  logic        ACK_I,
    input  logic [31:0] DAT_I,
    // debug
    output logic [1:0]  gnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT0 = 2'd1,
        S_GNT1 = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // Last counter value that is still a legal stall; one more stalled edge means timeout.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last;        // 0: M0 was granted last, 1: M1
    logic            w_last_nxt;
    logic [TO_W-1:0] r_to_cnt;
    logic [TO_W-1:0] w_to_cnt_nxt;

    logic            w_in_gnt;
    logic            w_sel_cyc;
    logic            w_sel_stb;
    logic            w_stall;
    logic            w_to_hit;

    // View of whichever master currently owns the bus.
    assign w_in_gnt  = (r_state == S_GNT0) || (r_state == S_GNT1);
    assign w_sel_cyc = (r_state == S_GNT1) ? m1_CYC_I : m0_CYC_I;
    assign w_sel_stb = (r_state == S_GNT1) ? m1_STB_I : m0_STB_I;
    assign w_stall   = w_in_gnt && w_sel_cyc && w_sel_stb && !ACK_I;
    // ACK_I high forces w_stall low, so an ACK on the threshold edge always wins.
    assign w_to_hit  = w_stall && (r_to_cnt == TO_LAST);

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b1;       // M0 wins the first contention after reset
            r_to_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_last   <= w_last_nxt;
            r_to_cnt <= w_to_cnt_nxt;
        end
    end

    // Next state, last-grant tracking and watchdog counter.
    always_comb begin
        w_state_nxt  = r_state;
        w_last_nxt   = r_last;
        w_to_cnt_nxt = '0;
        case (r_state)
            S_IDLE: begin
                if (m0_CYC_I && m1_CYC_I) begin
                    w_state_nxt = r_last ? S_GNT0 : S_GNT1;
                    w_last_nxt  = !r_last;
                end else if (m0_CYC_I) begin
                    w_state_nxt = S_GNT0;
                    w_last_nxt  = 1'b0;
                end else if (m1_CYC_I) begin
                    w_state_nxt = S_GNT1;
                    w_last_nxt  = 1'b1;
                end
            end
            S_GNT0, S_GNT1: begin
                // Dropping CYC releases the bus without ERR even if unacknowledged.
                if (!w_sel_cyc) begin
                    w_state_nxt = S_IDLE;
                end else if (w_to_hit) begin
                    w_state_nxt = S_ERR;
                end else if (w_stall) begin
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                end
            end
            S_ERR: begin
                // r_last still names the errored master, so the other one gets priority next.
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Bus muxing; everything outside GNT0/GNT1 is held at zero.
    always_comb begin
        CYC_O    = 1'b0;
        STB_O    = 1'b0;
        WE_O     = 1'b0;
        ADR_O    = '0;
        DAT_O    = '0;
        SEL_O    = '0;
        m0_ACK_O = 1'b0;
        m0_ERR_O = 1'b0;
        m0_DAT_O = '0;
        m1_ACK_O = 1'b0;
        m1_ERR_O = 1'b0;
        m1_DAT_O = '0;
        gnt_o    = 2'b00;
        case (r_state)
            S_GNT0: begin
                CYC_O    = m0_CYC_I;
                STB_O    = m0_STB_I;
                WE_O     = m0_WE_I;
                ADR_O    = m0_ADR_I;
                DAT_O    = m0_DAT_I;
                SEL_O    = m0_SEL_I;
                m0_ACK_O = ACK_I && m0_STB_I;
                m0_DAT_O = DAT_I;
                gnt_o    = 2'b01;
            end
            S_GNT1: begin
                CYC_O    = m1_CYC_I;
                STB_O    = m1_STB_I;
                WE_O     = m1_WE_I;
                ADR_O    = m1_ADR_I;
                DAT_O    = m1_DAT_I;
                SEL_O    = m1_SEL_I;
                m1_ACK_O = ACK_I && m1_STB_I;
                m1_DAT_O = DAT_I;
                gnt_o    = 2'b10;
            end
            S_ERR: begin
                m0_ERR_O = !r_last;
                m1_ERR_O = r_last;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter_rr2.sv
`timescale 1ns/1ps
module tb_wb_arbiter_rr2;

    logic        CLK_I = 1'b0;
    logic        RST_I;
    logic        m0_CYC_I, m0_STB_I, m0_WE_I;
    logic [31:0] m0_ADR_I, m0_DAT_I;
    logic [3:0]  m0_SEL_I;
    logic        m0_ACK_O, m0_ERR_O;
    logic [31:0] m0_DAT_O;
    logic        m1_CYC_I, m1_STB_I, m1_WE_I;
    logic [31:0] m1_ADR_I, m1_DAT_I;
    logic [3:0]  m1_SEL_I;
    logic        m1_ACK_O, m1_ERR_O;
    logic [31:0] m1_DAT_O;
    logic        CYC_O, STB_O, WE_O;
    logic [31:0] ADR_O, DAT_O;
    logic [3:0]  SEL_O;
    logic        ACK_I;
    logic [31:0] DAT_I;
    logic [1:0]  gnt_o;

    wb_arbiter_rr2 #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I),
        .m0_CYC_I(m0_CYC_I), .m0_STB_I(m0_STB_I), .m0_WE_I(m0_WE_I),
        .m0_ADR_I(m0_ADR_I), .m0_DAT_I(m0_DAT_I), .m0_SEL_I(m0_SEL_I),
        .m0_ACK_O(m0_ACK_O), .m0_ERR_O(m0_ERR_O), .m0_DAT_O(m0_DAT_O),
        .m1_CYC_I(m1_CYC_I), .m1_STB_I(m1_STB_I), .m1_WE_I(m1_WE_I),
        .m1_ADR_I(m1_ADR_I), .m1_DAT_I(m1_DAT_I), .m1_SEL_I(m1_SEL_I),
        .m1_ACK_O(m1_ACK_O), .m1_ERR_O(m1_ERR_O), .m1_DAT_O(m1_DAT_O),
        .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
        .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O),
        .ACK_I(ACK_I), .DAT_I(DAT_I),
        .gnt_o(gnt_o)
    );

    always #5 CLK_I = ~CLK_I;

    // Expected master-side responses: {m0_ACK, m1_ACK, m0_ERR, m1_ERR} and read data.
    typedef struct packed {
        logic [3:0]  flags;
        logic [31:0] dat;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [35:0] mon_obs;
    int          n_checks = 0;
    int          n_err    = 0;
    logic        exp_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK_I);
        #2;
    endtask

    task automatic push_exp(input logic [3:0] flags, input logic [31:0] dat);
        exp_t e;
        e.flags = flags;
        e.dat   = dat;
        sb_q.push_back(e);
    endtask

    task automatic set_m0(input logic c, input logic s, input logic w,
                          input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
        m0_CYC_I = c; m0_STB_I = s; m0_WE_I = w; m0_ADR_I = a; m0_DAT_I = d; m0_SEL_I = sl;
    endtask

    task automatic set_m1(input logic c, input logic s, input logic w,
                          input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
        m1_CYC_I = c; m1_STB_I = s; m1_WE_I = w; m1_ADR_I = a; m1_DAT_I = d; m1_SEL_I = sl;
    endtask

    // Every ACK/ERR seen by a master must match the next scoreboard entry.
    always @(negedge CLK_I) begin
        if (RST_I === 1'b1 && (m0_ACK_O || m1_ACK_O || m0_ERR_O || m1_ERR_O)) begin
            mon_obs = {m0_ACK_O, m1_ACK_O, m0_ERR_O, m1_ERR_O, m0_DAT_O | m1_DAT_O};
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_resp", 64'(mon_obs[35:32]), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_resp", 64'(mon_obs), 64'(mon_e));
            end
        end
    end

    initial begin
        RST_I = 1'b0;
        ACK_I = 1'b0;
        DAT_I = '0;
        set_m0(0, 0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0, 0);

        // ---------------- reset state ----------------
        #1;
        m0_CYC_I = 1'b1; m0_STB_I = 1'b1; ACK_I = 1'b1;
        #1;
        chk("rst_gnt", gnt_o, 2'b00);
        chk("rst_slave", {CYC_O, STB_O, WE_O, ADR_O, SEL_O}, '0);
        chk("rst_resp", {m0_ACK_O, m0_ERR_O, m1_ACK_O, m1_ERR_O}, 4'b0000);
        set_m0(0, 0, 0, 0, 0, 0);
        ACK_I = 1'b0;
        cyc();
        cyc();
        RST_I = 1'b1;

        // ---------------- 1: single M0 read ----------------
        set_m0(1, 1, 0, 32'h0800_0000, 0, 4'hF);
        #1;
        chk("t1_req_not_yet_gnt", gnt_o, 2'b00);
        cyc(); #1;
        chk("t1_gnt", gnt_o, 2'b01);
        chk("t1_slave_cyc_stb", {CYC_O, STB_O, WE_O}, 3'b110);
        chk("t1_adr", ADR_O, 32'h0800_0000);
        cyc();
        cyc();
        ACK_I = 1'b1; DAT_I = 32'hDEAD_BEEF;
        push_exp(4'b1000, 32'hDEAD_BEEF);
        #1;
        chk("t1_ack", {m0_ACK_O, m1_ACK_O}, 2'b10);
        chk("t1_rdata", m0_DAT_O, 32'hDEAD_BEEF);
        cyc();
        ACK_I = 1'b0; DAT_I = '0;
        set_m0(0, 0, 0, 0, 0, 0);
        #1;
        chk("t1_release_cyc", CYC_O, 1'b0);
        cyc(); #1;
        chk("t1_idle", gnt_o, 2'b00);

        // ---------------- 2: contention from reset, alternation ----------------
        RST_I = 1'b0;
        cyc();
        RST_I = 1'b1;
        set_m0(1, 1, 0, 32'h1000_0000, 0, 4'hF);
        set_m1(1, 1, 0, 32'h2000_0000, 0, 4'hF);
        for (int t = 0; t < 4; t++) begin
            exp_m = t[0];
            cyc();
            ACK_I = 1'b1; DAT_I = 32'hA000_0000 + 32'(t);
            push_exp(exp_m ? 4'b0100 : 4'b1000, 32'hA000_0000 + 32'(t));
            #1;
            chk("t2_rr_gnt", gnt_o, exp_m ? 2'b10 : 2'b01);
            chk("t2_rr_adr", ADR_O, exp_m ? 32'h2000_0000 : 32'h1000_0000);
            cyc();
            ACK_I = 1'b0; DAT_I = '0;
            if (exp_m) set_m1(0, 0, 0, 0, 0, 0);
            else       set_m0(0, 0, 0, 0, 0, 0);
            #1;
            chk("t2_release_cyc", CYC_O, 1'b0);
            cyc(); #1;
            chk("t2_idle_gap", gnt_o, 2'b00);
            if (exp_m) set_m1(1, 1, 0, 32'h2000_0000, 0, 4'hF);
            else       set_m0(1, 1, 0, 32'h1000_0000, 0, 4'hF);
        end
        set_m0(0, 0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0, 0);
        cyc();

        // ---------------- 3: M1 locked over 3 write beats ----------------
        set_m1(1, 1, 1, 32'h0000_0100, 32'h1234_ABCD, 4'b0011);
        cyc();
        set_m0(1, 1, 0, 32'h0000_0200, 0, 4'hF);
        for (int b = 0; b < 3; b++) begin
            m1_ADR_I = 32'h0000_0100 + 32'(4 * b);
            ACK_I = 1'b1;
            push_exp(4'b0100, 32'h0);
            #1;
            chk("t3_lock_gnt", gnt_o, 2'b10);
            chk("t3_beat_ctl", {CYC_O, STB_O, WE_O, SEL_O}, 7'b111_0011);
            chk("t3_beat_adr", ADR_O, 32'h0000_0100 + 32'(4 * b));
            chk("t3_beat_dat", DAT_O, 32'h1234_ABCD);
            cyc();
        end
        ACK_I = 1'b0;
        set_m1(0, 0, 0, 0, 0, 0);
        #1;
        chk("t3_still_m1", gnt_o, 2'b10);
        cyc(); #1;
        chk("t3_idle_gap", gnt_o, 2'b00);
        cyc();
        ACK_I = 1'b1; DAT_I = 32'h55AA_55AA;
        push_exp(4'b1000, 32'h55AA_55AA);
        #1;
        chk("t3_m0_after", gnt_o, 2'b01);
        chk("t3_m0_adr", ADR_O, 32'h0000_0200);
        cyc();
        ACK_I = 1'b0; DAT_I = '0;
        set_m0(0, 0, 0, 0, 0, 0);
        cyc();

        // ---------------- 4: timeout, then ACK just in time ----------------
        set_m0(1, 1, 0, 32'h0000_0300, 0, 4'hF);
        push_exp(4'b0010, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cyc(); #1;
            chk("t4_stall_gnt", {gnt_o, CYC_O, m0_ERR_O}, 4'b0110);
        end
        cyc();
        ACK_I = 1'b1; DAT_I = 32'h7777_7777;    // stray ACK in ERR must be ignored
        #1;
        chk("t4_err_cycle", {m0_ERR_O, m1_ERR_O, m0_ACK_O, CYC_O, STB_O}, 5'b10000);
        chk("t4_err_gnt", gnt_o, 2'b00);
        ACK_I = 1'b0; DAT_I = '0;
        set_m0(0, 0, 0, 0, 0, 0);
        cyc(); #1;
        chk("t4_err_one_cycle", {m0_ERR_O, gnt_o}, 3'b000);
        set_m0(1, 1, 0, 32'h0000_0304, 0, 4'hF);
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            chk("t4b_stall", {gnt_o, m0_ERR_O}, 3'b010);
        end
        cyc();
        ACK_I = 1'b1; DAT_I = 32'hC0FF_EE00;
        push_exp(4'b1000, 32'hC0FF_EE00);
        #1;
        chk("t4b_ack_wins", m0_ACK_O, 1'b1);
        cyc();
        ACK_I = 1'b0; DAT_I = '0;
        set_m0(0, 0, 0, 0, 0, 0);
        #1;
        chk("t4b_no_err", {gnt_o, m0_ERR_O}, 3'b010);
        cyc(); #1;
        chk("t4b_idle", {gnt_o, m0_ERR_O}, 3'b000);

        // ---------------- 5: async reset mid-transfer ----------------
        set_m1(1, 1, 0, 32'h0000_0400, 0, 4'hF);
        cyc();
        cyc(); #1;
        chk("t5_gnt1_stall", gnt_o, 2'b10);
        RST_I = 1'b0;
        #1;
        chk("t5_async_gnt", gnt_o, 2'b00);
        chk("t5_async_slave", {CYC_O, STB_O, ADR_O}, '0);
        set_m0(1, 1, 0, 32'h0000_0500, 0, 4'hF);
        cyc();
        cyc();
        RST_I = 1'b1;
        cyc();
        ACK_I = 1'b1; DAT_I = 32'h600D_0000;
        push_exp(4'b1000, 32'h600D_0000);
        #1;
        chk("t5_m0_wins", gnt_o, 2'b01);
        chk("t5_m0_ack", {m0_ACK_O, m1_ACK_O}, 2'b10);
        cyc();
        ACK_I = 1'b0; DAT_I = '0;
        set_m0(0, 0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0, 0);
        cyc();
        cyc();

        // ---------------- 6: stray ACK_I in IDLE ----------------
        for (int i = 0; i < 4; i++) begin
            ACK_I = i[0]; DAT_I = 32'hFFFF_FFFF;
            #1;
            chk("t6_stray_ack", {m0_ACK_O, m1_ACK_O, CYC_O}, 3'b000);
            chk("t6_stray_dat", m0_DAT_O | m1_DAT_O, 32'h0);
            cyc();
        end
        ACK_I = 1'b1;
        set_m1(1, 1, 0, 32'h0000_0600, 0, 4'hF);
        #1;
        chk("t6_req_cycle_ack", m1_ACK_O, 1'b0);
        cyc();
        DAT_I = 32'h0BAD_F00D;
        push_exp(4'b0100, 32'h0BAD_F00D);
        #1;
        chk("t6_gnt_ack", {gnt_o, m1_ACK_O}, 3'b101);
        cyc();
        ACK_I = 1'b0; DAT_I = '0;
        set_m1(0, 0, 0, 0, 0, 0);
        cyc();
        cyc();

        chk("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
